// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state encodings and default geometry.
// The default sizes are kept in step with memory_unit and its bench.
package mem_access_ctrl_pkg;

   localparam int MEMSIZE_DEF    = 16;
   localparam int WORDSIZE_DEF   = 4;
   localparam int LEN_W_DEF      = 4;
   localparam int RD_LATENCY_DEF = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/mem_rd_delay.sv
// Read-latency down-counter: start loads RD_LATENCY-2, done is high once it reaches zero.
// Gives RD_LATENCY-1 cycles of WAIT after the read strobe cycle; no backpressure.
module mem_rd_delay #(
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic done
);

   localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CW-1:0] LOAD = CW'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= LOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Requester-side sequencer for a single-port memory: posted single-beat writes, incrementing read bursts.
// First read beat 1+RD_LATENCY cycles after acceptance; a stalled response holds the FSM, no new strobes.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int MEMSIZE    = MEMSIZE_DEF,
   parameter int WORDSIZE   = WORDSIZE_DEF,
   parameter int LEN_W      = LEN_W_DEF,
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [MEMSIZE-1:0]  req_addr,
   input  logic [WORDSIZE-1:0] req_wdata,
   input  logic [LEN_W-1:0]    req_len,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WORDSIZE-1:0] rsp_rdata,
   output logic                rsp_last,
   output logic                mem_wren,
   output logic                mem_rden,
   output logic [MEMSIZE-1:0]  mem_addr,
   output logic [WORDSIZE-1:0] mem_d,
   input  logic [WORDSIZE-1:0] mem_q
);

   generate
      if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_lat_check
         $error("mem_access_ctrl: RD_LATENCY must be in 1..8");
      end
   endgenerate

   state_t           state;
   logic [LEN_W-1:0] beat_cnt;
   logic             delay_start;
   logic             delay_done;

   assign delay_start = (state == READ);

   mem_rd_delay #(
      .RD_LATENCY(RD_LATENCY)
   ) u_rd_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .start (delay_start),
      .done  (delay_done)
   );

   // mem_addr doubles as the burst address register: it only moves on acceptance or beat advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_rdata <= '0;
         mem_wren  <= 1'b0;
         mem_rden  <= 1'b0;
         mem_addr  <= '0;
         mem_d     <= '0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  mem_addr  <= req_addr;
                  if (req_we) begin
                     mem_wren <= 1'b1;
                     mem_d    <= req_wdata;
                     state    <= WRITE;
                  end else begin
                     mem_rden <= 1'b1;
                     beat_cnt <= req_len;
                     state    <= READ;
                  end
               end
            end
            WRITE: begin
               mem_wren  <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            READ: begin
               mem_rden <= 1'b0;
               // Single-cycle latency: data is already valid in the strobe cycle.
               if (RD_LATENCY == 1) begin
                  rsp_rdata <= mem_q;
                  rsp_valid <= 1'b1;
                  rsp_last  <= (beat_cnt == '0);
                  state     <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (delay_done) begin
                  rsp_rdata <= mem_q;
                  rsp_valid <= 1'b1;
                  rsp_last  <= (beat_cnt == '0);
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (rsp_last) begin
                     rsp_last  <= 1'b0;
                     req_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt - 1'b1;
                     mem_addr <= mem_addr + 1'b1;
                     mem_rden <= 1'b1;
                     state    <= READ;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a latency-1 and a latency-3 instance, each with its own memory model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   initial forever #5 clk = ~clk;

   // latency-1 instance
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_last, mem_wren, mem_rden;
   logic [15:0] req_addr, mem_addr;
   logic [3:0]  req_wdata, req_len, rsp_rdata, mem_d, mem_q;
   // latency-3 instance
   logic        l3_req_valid, l3_req_ready, l3_req_we, l3_rsp_valid, l3_rsp_ready, l3_rsp_last;
   logic        l3_mem_wren, l3_mem_rden;
   logic [15:0] l3_req_addr, l3_mem_addr;
   logic [3:0]  l3_req_wdata, l3_req_len, l3_rsp_rdata, l3_mem_d, l3_mem_q;

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
      .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
   );

   mem_access_ctrl #(.RD_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(l3_req_valid), .req_ready(l3_req_ready), .req_we(l3_req_we), .req_addr(l3_req_addr),
      .req_wdata(l3_req_wdata), .req_len(l3_req_len),
      .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_rdata(l3_rsp_rdata), .rsp_last(l3_rsp_last),
      .mem_wren(l3_mem_wren), .mem_rden(l3_mem_rden), .mem_addr(l3_mem_addr), .mem_d(l3_mem_d), .mem_q(l3_mem_q)
   );

   // Latency-1 memory: combinational read, unwritten words read as addr[3:0], noise when not strobed.
   logic [3:0] mem [0:65535];
   bit         written [0:65535];
   logic [3:0] rd_word;
   always @(posedge clk) if (mem_wren) begin
      mem[mem_addr]     <= mem_d;
      written[mem_addr] <= 1'b1;
   end
   always_comb rd_word = written[mem_addr] ? mem[mem_addr] : mem_addr[3:0];
   assign mem_q = mem_rden ? rd_word : ~rd_word;

   // Latency-3 memory: contents addr[3:0]^5, data valid only two cycles after the strobe cycle.
   logic       l3_p1v, l3_p2v;
   logic [3:0] l3_p1d, l3_p2d;
   always @(posedge clk) begin
      l3_p1v <= l3_mem_rden;
      l3_p1d <= l3_mem_addr[3:0] ^ 4'h5;
      l3_p2v <= l3_p1v;
      l3_p2d <= l3_p1d;
   end
   assign l3_mem_q = l3_p2v ? l3_p2d : ~l3_p2d;

   int   clash = 0;
   logic prev_wren = 1'b0, prev_rden = 1'b0;
   always @(negedge clk) begin
      if (rst_n && ((mem_wren && mem_rden) || (mem_wren && prev_wren) || (mem_rden && prev_rden) ||
                    (l3_mem_wren && l3_mem_rden)))
         clash <= clash + 1;
      prev_wren <= mem_wren;
      prev_rden <= mem_rden;
   end

   int total = 0;
   int bad   = 0;

   localparam logic [28:0] RST_VEC = {1'b1, 28'd0};

   logic [3:0]  ref_mem [logic [15:0]];
   logic [15:0] obs_addr [$];
   logic [3:0]  obs_data [$];
   logic        obs_last [$];
   int          obs_cyc  [$];
   int          first_rden, first_valid, stall_bad, stall_seen;
   bit          rd_timeout;

   function automatic logic [3:0] ref_word(input logic [15:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return a[3:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [3:0] d);
      int cyc = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_len = 4'($urandom);
      while (!req_ready && cyc < 50) begin tick(); cyc++; end
      tick();
      req_valid = 1'b0;
      tick();
      ref_mem[a] = d;
   endtask

   // Issues one read burst and records what happens; the scenario tasks judge the record.
   task automatic drive_read(input logic [15:0] a, input logic [3:0] len, input int sb, input int sn);
      int   cyc, beat, stall;
      bit   done;
      logic [4:0] held;
      obs_addr.delete(); obs_data.delete(); obs_last.delete(); obs_cyc.delete();
      first_rden = -1; first_valid = -1; stall_bad = 0; stall_seen = 0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len; req_wdata = 4'($urandom);
      cyc = 0;
      while (!req_ready && cyc < 50) begin tick(); cyc++; end
      tick();
      req_valid = 1'b0; req_addr = 16'($urandom); req_len = 4'($urandom);
      cyc = 1; beat = 0; stall = 0; done = 1'b0; held = '0;
      while (!done && cyc < 400) begin
         if (mem_rden) begin
            obs_addr.push_back(mem_addr);
            if (first_rden < 0) first_rden = cyc;
         end
         if (rsp_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (beat == sb && stall < sn) begin
               if (stall == 0) held = {rsp_last, rsp_rdata};
               else if ({rsp_last, rsp_rdata} !== held) stall_bad++;
               if (mem_rden) stall_bad++;
               stall++; stall_seen++;
               rsp_ready = 1'b0;
            end else begin
               if (beat == sb && stall > 0 && {rsp_last, rsp_rdata} !== held) stall_bad++;
               rsp_ready = 1'b1;
               obs_data.push_back(rsp_rdata); obs_last.push_back(rsp_last); obs_cyc.push_back(cyc);
               beat++;
               if (rsp_last) done = 1'b1;
            end
         end else begin
            rsp_ready = 1'($urandom);
         end
         tick();
         cyc++;
      end
      rd_timeout = !done;
      rsp_ready = 1'b1;
   endtask

   // Counts beat data, address and last-flag disagreements against the reference memory.
   function automatic int burst_errs(input logic [15:0] a, input int n);
      int e = 0;
      if (rd_timeout) e++;
      if (obs_data.size() != n || obs_addr.size() != n) return e + 1;
      for (int i = 0; i < n; i++) begin
         if (obs_addr[i] !== 16'(a + 16'(i))) e++;
         if (obs_data[i] !== ref_word(16'(a + 16'(i)))) e++;
         if (obs_last[i] !== (i == n - 1)) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_len = 0; rsp_ready = 1;
      l3_req_valid = 0; l3_req_we = 0; l3_req_addr = 0; l3_req_wdata = 0; l3_req_len = 0; l3_rsp_ready = 1;
      repeat (3) tick();
      total++;
      if ({req_ready, rsp_valid, rsp_last, mem_wren, mem_rden, mem_addr, mem_d, rsp_rdata} !== RST_VEC) begin
         bad++;
         $display("FAIL reset_lat1: got %h want %h",
                  {req_ready, rsp_valid, rsp_last, mem_wren, mem_rden, mem_addr, mem_d, rsp_rdata}, RST_VEC);
      end
      total++;
      if ({l3_req_ready, l3_rsp_valid, l3_rsp_last, l3_mem_wren, l3_mem_rden, l3_mem_addr, l3_mem_d,
           l3_rsp_rdata} !== RST_VEC) begin
         bad++;
         $display("FAIL reset_lat3: got %h want %h", {l3_req_ready, l3_rsp_valid, l3_rsp_last, l3_mem_wren,
                  l3_mem_rden, l3_mem_addr, l3_mem_d, l3_rsp_rdata}, RST_VEC);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
      total++;
      if ({req_ready, rsp_valid, mem_wren, mem_rden} !== 4'b1000) begin
         bad++;
         $display("FAIL idle_after_reset: got %b want 1000", {req_ready, rsp_valid, mem_wren, mem_rden});
      end
   endtask

   task automatic test_write();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0003; req_wdata = 4'hA;
      tick();
      req_addr = 16'h0100; req_wdata = 4'h6;
      total++;
      if ({mem_wren, mem_rden, mem_addr, mem_d, req_ready, rsp_valid} !== {2'b10, 16'h0003, 4'hA, 2'b00}) begin
         bad++;
         $display("FAIL write_strobe: got wren=%b rden=%b addr=%h d=%h rdy=%b vld=%b want 1 0 0003 a 0 0",
                  mem_wren, mem_rden, mem_addr, mem_d, req_ready, rsp_valid);
      end
      tick();
      total++;
      if ({mem_wren, mem_addr, mem_d, req_ready, rsp_valid} !== {1'b0, 16'h0003, 4'hA, 2'b10}) begin
         bad++;
         $display("FAIL write_gap: got wren=%b addr=%h d=%h rdy=%b vld=%b want 0 0003 a 1 0",
                  mem_wren, mem_addr, mem_d, req_ready, rsp_valid);
      end
      tick();
      req_valid = 1'b0;
      total++;
      if ({mem_wren, mem_addr, mem_d, req_ready} !== {1'b1, 16'h0100, 4'h6, 1'b0}) begin
         bad++;
         $display("FAIL write_back_to_back: got wren=%b addr=%h d=%h rdy=%b want 1 0100 6 0",
                  mem_wren, mem_addr, mem_d, req_ready);
      end
      tick();
      ref_mem[16'h0003] = 4'hA;
      ref_mem[16'h0100] = 4'h6;
      total++;
      if (mem[16'h0003] !== 4'hA || mem[16'h0100] !== 4'h6) begin
         bad++;
         $display("FAIL write_landed: got %h %h want a 6", mem[16'h0003], mem[16'h0100]);
      end
   endtask

   task automatic test_single_read();
      drive_read(16'h0003, 4'd0, -1, 0);
      total++;
      if (first_rden !== 1 || first_valid !== 2) begin
         bad++;
         $display("FAIL single_read_timing: got rden@%0d valid@%0d want rden@1 valid@2", first_rden, first_valid);
      end
      total++;
      if (obs_data.size() != 1 || obs_data[0] !== 4'hA || obs_last[0] !== 1'b1) begin
         bad++;
         $display("FAIL single_read_data: got beats=%0d data=%h last=%b want 1 a 1",
                  obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 4'h0, obs_last.size() > 0 ? obs_last[0] : 1'b0);
      end
      total++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL single_read_idle: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_burst_wrap();
      logic [15:0] ea;
      drive_read(16'hFFFE, 4'd3, -1, 0);
      total++;
      if (rd_timeout || obs_data.size() != 4 || obs_addr.size() != 4) begin
         bad++;
         $display("FAIL wrap_beats: got beats=%0d strobes=%0d timeout=%b want 4 4 0",
                  obs_data.size(), obs_addr.size(), rd_timeout);
      end else begin
         for (int i = 0; i < 4; i++) begin
            ea = 16'hFFFE + 16'(i);
            total++;
            if ({obs_addr[i], obs_data[i], obs_last[i]} !== {ea, ref_word(ea), i == 3}) begin
               bad++;
               $display("FAIL wrap_beat%0d: got addr=%h data=%h last=%b want %h %h %b",
                        i, obs_addr[i], obs_data[i], obs_last[i], ea, ref_word(ea), i == 3);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] a;
      int e;
      a = 16'($urandom_range(16'h0020, 16'h003F));
      drive_read(a, 4'd3, 1, 5);
      e = burst_errs(a, 4);
      total++;
      if (e != 0) begin
         bad++;
         $display("FAIL bp_data: got %0d beat errors want 0", e);
      end
      total++;
      if (stall_bad != 0 || stall_seen != 5) begin
         bad++;
         $display("FAIL bp_stall: got unstable=%0d stall_cycles=%0d want 0 5", stall_bad, stall_seen);
      end
      total++;
      if (obs_cyc.size() != 4 || obs_cyc[1] - obs_cyc[0] != 7 || obs_cyc[2] - obs_cyc[1] != 2 ||
          obs_cyc[3] - obs_cyc[2] != 2) begin
         bad++;
         $display("FAIL bp_spacing: got %0d handshakes gaps %0d %0d %0d want 7 2 2", obs_cyc.size(),
                  obs_cyc.size() == 4 ? obs_cyc[1] - obs_cyc[0] : -1,
                  obs_cyc.size() == 4 ? obs_cyc[2] - obs_cyc[1] : -1,
                  obs_cyc.size() == 4 ? obs_cyc[3] - obs_cyc[2] : -1);
      end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0003; req_len = 4'd0; rsp_ready = 1'b1;
      tick();
      req_we = 1'b1; req_addr = 16'h0200; req_wdata = 4'h5;
      tick();
      total++;
      if ({rsp_valid, rsp_rdata, req_ready, mem_wren} !== {1'b1, ref_word(16'h0003), 2'b00}) begin
         bad++;
         $display("FAIL b2b_resp: got vld=%b data=%h rdy=%b wren=%b want 1 %h 0 0",
                  rsp_valid, rsp_rdata, req_ready, mem_wren, ref_word(16'h0003));
      end
      tick();
      total++;
      if ({rsp_valid, req_ready, mem_wren} !== 3'b010) begin
         bad++;
         $display("FAIL b2b_idle: got vld=%b rdy=%b wren=%b want 0 1 0", rsp_valid, req_ready, mem_wren);
      end
      tick();
      req_valid = 1'b0;
      total++;
      if ({mem_wren, mem_addr, mem_d, req_ready} !== {1'b1, 16'h0200, 4'h5, 1'b0}) begin
         bad++;
         $display("FAIL b2b_write: got wren=%b addr=%h d=%h rdy=%b want 1 0200 5 0",
                  mem_wren, mem_addr, mem_d, req_ready);
      end
      tick();
      ref_mem[16'h0200] = 4'h5;
   endtask

   task automatic test_latency3();
      int   rcyc;
      int   vcyc [$];
      logic [4:0] vdat [$];
      l3_req_valid = 1'b1; l3_req_we = 1'b0; l3_req_addr = 16'h1234; l3_req_len = 4'd1; l3_rsp_ready = 1'b1;
      tick();
      l3_req_valid = 1'b0;
      rcyc = -1;
      for (int cyc = 1; cyc < 30 && vcyc.size() < 2; cyc++) begin
         if (l3_mem_rden && rcyc < 0) rcyc = cyc;
         if (l3_rsp_valid) begin
            vcyc.push_back(cyc);
            vdat.push_back({l3_rsp_last, l3_rsp_rdata});
         end
         tick();
      end
      total++;
      if (rcyc != 1 || vcyc.size() != 2 || vcyc[0] != 4 || vcyc[1] != 8) begin
         bad++;
         $display("FAIL lat3_timing: got rden@%0d valid@%0d,%0d want 1 4,8", rcyc,
                  vcyc.size() > 0 ? vcyc[0] : -1, vcyc.size() > 1 ? vcyc[1] : -1);
      end
      total++;
      if (vdat.size() != 2 || vdat[0] !== 5'h01 || vdat[1] !== 5'h10) begin
         bad++;
         $display("FAIL lat3_data: got %h %h want 01 10",
                  vdat.size() > 0 ? vdat[0] : 5'h0, vdat.size() > 1 ? vdat[1] : 5'h0);
      end
      total++;
      if ({l3_rsp_valid, l3_req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL lat3_idle: got vld=%b rdy=%b want 0 1", l3_rsp_valid, l3_req_ready);
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [3:0]  len;
      int sb, sn, e;
      for (int n = 0; n < 30; n++) begin
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                         : 16'($urandom_range(16'h0020, 16'h003F));
         if ($urandom_range(0, 2) == 0) begin
            do_write(a, 4'($urandom));
         end else begin
            len = 4'($urandom);
            sb  = $urandom_range(0, int'(len));
            sn  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            drive_read(a, len, sb, sn);
            e = burst_errs(a, int'(len) + 1) + stall_bad + ((stall_seen != sn) ? 1 : 0);
            total++;
            if (e != 0) begin
               bad++;
               $display("FAIL random_read%0d: addr=%h len=%0d stall=%0d@%0d got %0d errors want 0",
                        n, a, len, sn, sb, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int cyc, stray;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0030; req_len = 4'd7; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      seen = 1'b0; cyc = 0;
      while (!seen && cyc < 20) begin seen = rsp_valid; tick(); cyc++; end
      total++;
      if ({mem_rden, mem_addr} !== {1'b1, 16'h0031}) begin
         bad++;
         $display("FAIL mid_beat2_strobe: got rden=%b addr=%h want 1 0031", mem_rden, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({req_ready, rsp_valid, rsp_last, mem_wren, mem_rden, mem_addr, mem_d, rsp_rdata} !== RST_VEC) begin
         bad++;
         $display("FAIL mid_reset_values: got %h want %h",
                  {req_ready, rsp_valid, rsp_last, mem_wren, mem_rden, mem_addr, mem_d, rsp_rdata}, RST_VEC);
      end
      tick(); tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      stray = 0;
      repeat (12) begin
         if (rsp_valid || rsp_last || mem_rden) stray++;
         tick();
      end
      total++;
      if (stray != 0) begin
         bad++;
         $display("FAIL mid_stray_activity: got %0d cycles want 0", stray);
      end
      do_write(16'h0040, 4'h9);
      total++;
      if ({mem[16'h0040], rsp_valid, req_ready} !== {4'h9, 2'b01}) begin
         bad++;
         $display("FAIL mid_post_write: got mem=%h vld=%b rdy=%b want 9 0 1", mem[16'h0040], rsp_valid, req_ready);
      end
   endtask

   task automatic test_strobe_rules();
      total++;
      if (clash != 0) begin
         bad++;
         $display("FAIL strobe_rules: got %0d violations want 0", clash);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_single_read();
      test_burst_wrap();
      test_backpressure();
      test_back_to_back();
      test_latency3();
      test_random();
      test_reset_mid();
      test_strobe_rules();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
